spi_flash_xip: RTL and testbench
================================

Name: spi_flash_xip

Overview:
- Read-only Wishbone slave on the interconnect's SPI-flash port. Each bus read is turned into one SPI READ (0x03) transaction to an external serial NOR flash. The 32-bit word read from the flash is returned on the bus.
- Lets the core fetch or load from flash with no software driver.
- Sits directly downstream of the Wishbone interconnect's wb_spi_flash slave port and drives the flash pins.

Parameters:
- CLK_DIV, 2, half-period of sck_o in wb_clk_i cycles; legal range 1..255.
- ADDR_BITS, 24, flash address width sent after the command byte; fixed at 24 for this revision.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous, active-high reset
- wb_adr_i  in  32  byte address; only bits [23:2] are used
- wb_dat_i  in  32  write data; ignored
- wb_sel_i  in  4  byte selects; ignored, a full word is always returned
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  read termination, one-cycle pulse
- wb_err_o  out  1  write termination, one-cycle pulse
- sck_o  out  1  SPI clock, mode 0
- ss_o  out  1  flash chip select, active low
- mosi_o  out  1  master out
- miso_i  in  1  master in

Behaviour:
- Reset values: wb_dat_o=0, wb_ack_o=0, wb_err_o=0, sck_o=0, ss_o=1, mosi_o=0. State is IDLE.
- Reset is synchronous and active-high. It overrides any state, including mid-transfer: the outputs above take effect on the first edge with wb_rst_i=1, and no ack is issued.
- States: IDLE, XFER, RESP, GAP.
- IDLE:
  - If cyc&stb&we: wb_err_o=1 for one cycle, then IDLE. No flash activity.
  - If cyc&stb&!we: latch frame = {8'h03, 8'h00 ^ wb_adr_i[23:16], wb_adr_i[15:8], wb_adr_i[7:2], 2'b00}. Go to XFER. The accept cycle is T0.
- XFER: 64 bits, each 2*CLK_DIV cycles long.
  - T0+1: ss_o=0, sck_o=0, mosi_o=frame[31] (command MSB first), then the address MSB first.
  - Each bit: sck_o low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - miso_i is sampled on the clk edge that raises sck_o.
  - mosi_o advances on the edge that lowers sck_o.
  - Bits 32..63: mosi_o=0; miso_i is shifted into the data register.
- Byte order is little-endian: the first flash byte goes to wb_dat_o[7:0] and the fourth to [31:24]. Within each byte, MSB is first.
- RESP: entered at T0+1+128*CLK_DIV.
  - sck_o=0, ss_o=1, wb_dat_o=assembled word, wb_ack_o=1 for exactly one cycle.
  - With CLK_DIV=2, the ack is at T0+257.
- GAP: ss_o held high for 2*CLK_DIV cycles, then IDLE. New requests are not accepted in GAP (stb is simply not acked).
- Abort: cyc_i=0 during XFER makes the next cycle sck_o=0, ss_o=1, no ack, then GAP.
- Only one transfer is ever outstanding.
- wb_adr_i[1:0] and bits [31:24] are ignored; the interconnect does the address decoding.
- wb_dat_o holds its value until the next RESP.
- wb_ack_o and wb_err_o are never high together.
- Counters: bit counter 6 bits (0..63) with a terminal compare, no wrap. Divider counter 8 bits, reloads at CLK_DIV-1.

Decomposition:
- Package spi_flash_pkg holds:
  - state enum (IDLE, XFER, RESP, GAP)
  - CMD_READ=8'h03
  - FRAME_BITS=64
  - HDR_BITS=32
- Sub-module spi_flash_bit_timer takes CLK_DIV and start/abort inputs. It produces sck_o, a rise strobe, a fall strobe and last_bit.
- The top level holds the FSM, the shift registers and the Wishbone logic.

Test Plan:
- Flash model holds bytes EF,BE,AD,DE at 0x000100. Read wb_adr_i=0x0000_0100 with CLK_DIV=2 -> MOSI carries 03 00 01 00; ack at T0+257 with wb_dat_o=0xDEADBEEF; ss_o=1 on the ack cycle.
- Read wb_adr_i=0x3000_0103 -> flash address 0x000100 is sent and the same data 0xDEADBEEF is returned.
- Write of any data to 0x0000_0000 -> wb_err_o=1 for one cycle at T0+1, wb_ack_o stays 0, ss_o stays 1, sck_o does not toggle.
- Two back-to-back reads with stb held -> ss_o high for at least 4 cycles between the frames; second ack 4+257 cycles after the first.
- cyc_i dropped at T0+50 -> ss_o=1 and sck_o=0 at T0+51, no ack. A following read completes correctly.
- wb_rst_i pulsed for one cycle at T0+100 -> all outputs at reset values after that edge, no ack. The next read returns the correct word. Repeat the scenario-1 read with CLK_DIV=1 -> ack at T0+129.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash execute-in-place read port.
package spi_flash_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam int         FRAME_BITS = 64;
    localparam int         HDR_BITS   = 32;

    // The flash returns the lowest-addressed byte first; the bus word is little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_bit_timer.sv
// Generates the mode-0 SPI clock for one 64-bit frame, with edge strobes that
// line up with the system clock edges that move sck_o.
module spi_flash_bit_timer
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic abort_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o,
    output logic last_bit_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    logic       active_q, active_d;
    logic       sck_q, sck_d;
    logic [7:0] div_q, div_d;
    logic [5:0] bit_q, bit_d;
    logic       div_end_s;

    // Strobes are high during the cycle whose closing edge moves sck.
    always_comb begin
        div_end_s  = (div_q == DIV_LAST);
        rise_o     = active_q & ~sck_q & div_end_s;
        fall_o     = active_q & sck_q & div_end_s;
        last_bit_o = (bit_q == LAST_BIT);
    end

    // Divider and bit counting; abort wins over a coincident start.
    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        div_d    = div_q;
        bit_d    = bit_q;
        if (abort_i) begin
            active_d = 1'b0;
            sck_d    = 1'b0;
            div_d    = 8'd0;
            bit_d    = 6'd0;
        end else if (start_i) begin
            active_d = 1'b1;
            sck_d    = 1'b0;
            div_d    = 8'd0;
            bit_d    = 6'd0;
        end else if (active_q) begin
            if (div_end_s) begin
                div_d = 8'd0;
                sck_d = ~sck_q;
                if (sck_q) begin
                    if (last_bit_o) begin
                        active_d = 1'b0;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end else begin
                    bit_d = bit_q;
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end else begin
            div_d = 8'd0;
        end
    end

    // Timer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= 8'd0;
            bit_q    <= 6'd0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/spi_flash_xip.sv
// Wishbone read-only slave: each read becomes one SPI READ (0x03) of a 32-bit
// word from serial NOR flash; writes are terminated with an error.
module spi_flash_xip
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int ADDR_BITS = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        sck_o,
    output logic        ss_o,
    output logic        mosi_o,
    input  logic        miso_i
);

    localparam logic [8:0] GAP_LOAD = 9'(2 * CLK_DIV - 2);

    state_e              state_q, state_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                ss_q, ss_d;
    logic [31:0]         dat_q, dat_d;
    logic [HDR_BITS-1:0] tx_q, tx_d;
    logic [31:0]         rx_q, rx_d;
    logic [8:0]          gap_q, gap_d;

    logic                 start_s, abort_s, rise_s, fall_s, last_bit_s, req_s;
    logic [ADDR_BITS-1:0] flash_adr_s;
    logic [HDR_BITS-1:0]  hdr_s;
    logic                 unused_s;

    assign unused_s    = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:ADDR_BITS], wb_adr_i[1:0]};
    assign flash_adr_s = {wb_adr_i[ADDR_BITS-1:2], 2'b00};
    assign hdr_s       = {CMD_READ, 8'h00 ^ flash_adr_s[23:16], flash_adr_s[15:0]};
    // err_q guard keeps a held strobe from being errored twice.
    assign req_s       = wb_cyc_i & wb_stb_i & ~err_q;

    spi_flash_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .start_i    (start_s),
        .abort_i    (abort_s),
        .sck_o      (sck_o),
        .rise_o     (rise_s),
        .fall_o     (fall_s),
        .last_bit_o (last_bit_s)
    );

    // Transfer FSM: next state, shift registers and bus terminations.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        ss_d    = ss_q;
        dat_d   = dat_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        gap_d   = gap_q;
        start_s = 1'b0;
        abort_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (wb_we_i) begin
                        err_d = 1'b1;
                    end else begin
                        start_s = 1'b1;
                        ss_d    = 1'b0;
                        tx_d    = hdr_s;
                        state_d = XFER;
                    end
                end else begin
                    ss_d = 1'b1;
                end
            end
            XFER: begin
                if (!wb_cyc_i) begin
                    abort_s = 1'b1;
                    ss_d    = 1'b1;
                    tx_d    = '0;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end else if (rise_s) begin
                    // Only the last 32 sampled bits survive: the data phase.
                    rx_d = {rx_q[30:0], miso_i};
                end else if (fall_s) begin
                    if (last_bit_s) begin
                        ss_d    = 1'b1;
                        ack_d   = 1'b1;
                        dat_d   = bswap32(rx_q);
                        state_d = RESP;
                    end else begin
                        tx_d = {tx_q[HDR_BITS-2:0], 1'b0};
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
            RESP: begin
                gap_d   = GAP_LOAD;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == 9'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 9'd1;
                end
            end
            default: begin
                ss_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ss_q    <= 1'b1;
            dat_q   <= 32'd0;
            tx_q    <= '0;
            rx_q    <= 32'd0;
            gap_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            ss_q    <= ss_d;
            dat_q   <= dat_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            gap_q   <= gap_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign ss_o     = ss_q;
    assign mosi_o   = tx_q[HDR_BITS-1];

endmodule

// File: tb/tb_spi_flash_xip.sv
// Scoreboard bench for spi_flash_xip: instance 0 runs CLK_DIV=2, instance 1 CLK_DIV=1,
// each attached to a behavioural serial flash.
module tb_spi_flash_xip;

    typedef struct {
        int          k;
        bit          is_err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int          k;
        logic [31:0] hdr;
    } hdr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cnum = 0;
    always @(posedge clk) cnum <= cnum + 1;

    logic [1:0]  rst = 2'b11, we = 2'b00, cyc = 2'b00, stb = 2'b00, miso = 2'b00;
    logic [31:0] adr [2];
    logic [31:0] dati [2];
    logic [3:0]  sel [2];
    wire  [1:0]  ack, err, sck, ss, mosi;
    wire  [31:0] dato0, dato1;

    int   checks = 0;
    int   fails  = 0;
    exp_t sbq[$];
    hdr_t hq[$];

    spi_flash_xip #(.CLK_DIV(2), .ADDR_BITS(24)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst[0]), .wb_adr_i(adr[0]), .wb_dat_i(dati[0]),
        .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_dat_o(dato0), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .sck_o(sck[0]),
        .ss_o(ss[0]), .mosi_o(mosi[0]), .miso_i(miso[0])
    );

    spi_flash_xip #(.CLK_DIV(1), .ADDR_BITS(24)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst[1]), .wb_adr_i(adr[1]), .wb_dat_i(dati[1]),
        .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_dat_o(dato1), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .sck_o(sck[1]),
        .ss_o(ss[1]), .mosi_o(mosi[1]), .miso_i(miso[1])
    );

    function automatic int divk(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] dat_of(int k);
        return (k == 0) ? dato0 : dato1;
    endfunction

    // Flash contents: fixed test bytes at 0x100, a hash of the address elsewhere.
    function automatic logic [7:0] flash_byte(logic [23:0] a);
        case (a)
            24'h000100: return 8'hEF;
            24'h000101: return 8'hBE;
            24'h000102: return 8'hAD;
            24'h000103: return 8'hDE;
            default:    return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(logic [31:0] a);
        logic [23:0] b;
        b = {a[23:2], 2'b00};
        return {flash_byte(b + 24'd3), flash_byte(b + 24'd2), flash_byte(b + 24'd1), flash_byte(b)};
    endfunction

    function automatic logic [31:0] ref_hdr(logic [31:0] a);
        return {8'h03, a[23:2], 2'b00};
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cnum);
        end
    endtask

    // Behavioural serial flash: command/address on sck rises, data driven after falls.
    int          fcnt [2] = '{0, 0};
    int          fnz  [2] = '{0, 0};
    logic [31:0] fhdr [2] = '{32'd0, 32'd0};
    logic [1:0]  psck = 2'b00;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ss[k]) begin
                fcnt[k] = 0;
                fnz[k]  = 0;
                miso[k] = 1'b0;
            end else if (sck[k] && !psck[k]) begin
                if (fcnt[k] < 32) fhdr[k] = {fhdr[k][30:0], mosi[k]};
                else if (mosi[k]) fnz[k]++;
                fcnt[k]++;
                if (fcnt[k] == 32) begin
                    if (hq.size() == 0) begin
                        chk("unexpected_frame", 64'(fhdr[k]), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        hdr_t h;
                        h = hq.pop_front();
                        chk("frame_dut", 64'(k), 64'(h.k));
                        chk("mosi_header", 64'(fhdr[k]), 64'(h.hdr));
                    end
                end
                if (fcnt[k] == 64) chk("mosi_data_phase_zero", 64'(fnz[k]), 64'd0);
            end else if (!sck[k] && psck[k] && fcnt[k] >= 32 && fcnt[k] < 64) begin
                logic [7:0] fb;
                fb      = flash_byte(fhdr[k][23:0] + 24'((fcnt[k] - 32) / 8));
                miso[k] = fb[7 - ((fcnt[k] - 32) % 8)];
            end
            psck[k] = sck[k];
        end
    end

    // Monitor: every termination pops the scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ack[k] && err[k]) begin
                chk("ack_err_exclusive", {ack[k], err[k]}, 64'd0);
            end else if (ack[k] || err[k]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_termination", {ack[k], err[k]}, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("term_dut", 64'(k), 64'(e.k));
                    chk("term_kind_err", 64'(err[k]), 64'(e.is_err));
                    chk("term_cycle", 64'(cnum), 64'(e.cyc));
                    if (!e.is_err) begin
                        chk("read_data", 64'(dat_of(k)), 64'(e.data));
                        chk("ss_high_on_ack", 64'(ss[k]), 64'd1);
                    end
                end
            end
        end
    end

    task automatic rd(int k, logic [31:0] a, int n);
        int t0, d, got, ssrun;
        @(posedge clk); #1;
        adr[k] = a; we[k] = 1'b0; cyc[k] = 1'b1; stb[k] = 1'b1;
        t0 = cnum; d = divk(k);
        for (int i = 0; i < n; i++) begin
            sbq.push_back('{k, 1'b0, ref_word(a), t0 + 1 + 128 * d + i * (2 * d + 1 + 128 * d)});
            hq.push_back('{k, ref_hdr(a)});
        end
        got = 0; ssrun = 0;
        for (int c = 0; c < 1200 && got < n; c++) begin
            @(negedge clk);
            if (ack[k]) got++;
            else if (got == 1 && ss[k]) ssrun++;
        end
        chk("ack_count", 64'(got), 64'(n));
        @(posedge clk); #1;
        cyc[k] = 1'b0; stb[k] = 1'b0;
        if (n == 2) chk("gap_ss_high_ge_2div", 64'(ssrun >= 2 * d), 64'd1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("dat_hold", 64'(dat_of(k)), 64'(ref_word(a)));
    endtask

    task automatic wr(int k, logic [31:0] a);
        int bad;
        @(posedge clk); #1;
        adr[k] = a; dati[k] = $urandom; sel[k] = 4'hF; we[k] = 1'b1; cyc[k] = 1'b1; stb[k] = 1'b1;
        sbq.push_back('{k, 1'b1, 32'd0, cnum + 1});
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sck[k] || !ss[k]) bad++;
            if (i == 1) begin
                @(posedge clk); #1;
                cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            end
        end
        chk("write_no_flash_activity", 64'(bad), 64'd0);
    endtask

    // Start a read, then drop cyc (or pulse reset) 'at' cycles after acceptance.
    task automatic ab(int k, logic [31:0] a, int at, bit use_rst);
        int nack;
        @(posedge clk); #1;
        adr[k] = a; we[k] = 1'b0; cyc[k] = 1'b1; stb[k] = 1'b1;
        repeat (at) @(posedge clk);
        #1;
        cyc[k] = 1'b0; stb[k] = 1'b0;
        if (use_rst) rst[k] = 1'b1;
        @(negedge clk);
        chk("ss_low_before_abort", 64'(ss[k]), 64'd0);
        @(posedge clk); #1;
        rst[k] = 1'b0;
        @(negedge clk);
        chk("abort_ss_sck", {ss[k], sck[k]}, 64'b10);
        if (use_rst) begin
            chk("rst_dat_zero", 64'(dat_of(k)), 64'd0);
            chk("rst_ack_err_mosi", {ack[k], err[k], mosi[k]}, 64'd0);
        end
        nack = 0;
        repeat (300) begin
            @(negedge clk);
            if (ack[k]) nack++;
        end
        chk("no_ack_after_abort", 64'(nack), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cnum);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            adr[k] = 32'd0; dati[k] = 32'd0; sel[k] = 4'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_dat", 64'(dat_of(k)), 64'd0);
            chk("reset_ctl", {ack[k], err[k], sck[k], ss[k], mosi[k]}, 64'b00010);
        end
        @(posedge clk); #1;
        rst = 2'b00;

        rd(0, 32'h0000_0100, 1);
        rd(0, 32'h3000_0103, 1);
        wr(0, 32'h0000_0000);
        rd(0, $urandom, 2);
        ab(0, $urandom, 50, 1'b0);
        rd(0, 32'h0000_0100, 1);
        ab(0, $urandom, 100, 1'b1);
        rd(0, 32'h0000_0100, 1);
        repeat (5) rd(0, $urandom, 1);

        rd(1, 32'h0000_0100, 1);
        wr(1, $urandom);
        rd(1, $urandom, 2);
        ab(1, $urandom, 20, 1'b0);
        repeat (4) rd(1, $urandom, 1);

        repeat (20) @(posedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        chk("headers_drained", 64'(hq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
